// File: rtl/knn_pkg.sv
// Shared kNN definitions: training-set dimensions, record types and loader states.
package knn_pkg;

    localparam int NPoints = 17;
    localparam int Classes = 2;
    localparam int CoordW  = 16;

    localparam int CW   = (Classes > 1) ? $clog2(Classes) : 1;
    localparam int CntW = $clog2(NPoints + 1);

    typedef logic [CW-1:0] class_t;

    typedef struct packed {
        logic [CoordW-1:0] x;
        logic [CoordW-1:0] y;
    } point_t;

    // state    | meaning
    // ST_IDLE  | after reset, waiting for start_i
    // ST_LOAD  | accepting records into entry[count]
    // ST_DONE  | all entries written, loaded_o high, records refused
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

endpackage

// File: rtl/knn_trainset_loader.sv
// Training-set write port for the kNN classifier: serial (point, class) records
// are written into a flop bank that drives the classifier in parallel.
module knn_trainset_loader #(
    parameter int NPoints = knn_pkg::NPoints,
    parameter int Classes = knn_pkg::Classes,
    parameter int CoordW  = knn_pkg::CoordW,
    localparam int ClsW   = (Classes > 1) ? $clog2(Classes) : 1,
    localparam int CntWL  = $clog2(NPoints + 1),
    localparam int PtW    = 2 * CoordW
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [PtW-1:0]   wr_point_i,
    input  logic [ClsW-1:0]  wr_class_i,
    output logic [PtW-1:0]   points_o  [NPoints],
    output logic [ClsW-1:0]  classes_o [NPoints],
    output logic [CntWL-1:0] count_o,
    output logic             loaded_o,
    output logic             err_o
);
    import knn_pkg::*;

    load_state_t state;
    logic        class_bad;

    // A label is out of range when it is not below Classes; the extra bit keeps
    // the compare exact when Classes is a power of two.
    assign class_bad = ({1'b0, wr_class_i} >= (ClsW + 1)'(Classes));

    // Loader FSM; wr_ready_o is registered alongside the state so it never
    // depends combinationally on wr_valid_i. start_i wins over a handshake.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= ST_IDLE;
            wr_ready_o <= 1'b0;
            count_o    <= '0;
            loaded_o   <= 1'b0;
            err_o      <= 1'b0;
            for (int i = 0; i < NPoints; i++) begin
                points_o[i]  <= '0;
                classes_o[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state      <= ST_LOAD;
                        wr_ready_o <= 1'b1;
                        count_o    <= '0;
                        loaded_o   <= 1'b0;
                        err_o      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (start_i) begin
                        count_o <= '0;
                        err_o   <= 1'b0;
                    end else if (wr_valid_i) begin
                        for (int i = 0; i < NPoints; i++) begin
                            if (count_o == CntWL'(i)) begin
                                points_o[i]  <= wr_point_i;
                                classes_o[i] <= wr_class_i;
                            end
                        end
                        count_o <= count_o + 1'b1;
                        if (class_bad) begin
                            err_o <= 1'b1;
                        end
                        if (count_o == CntWL'(NPoints - 1)) begin
                            state      <= ST_DONE;
                            wr_ready_o <= 1'b0;
                            loaded_o   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    wr_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knn_trainset_loader.sv
// Bench for knn_trainset_loader: randomized loads against a record-level model,
// scoreboard queue checked by a monitor at each falling edge.
module tb_knn_trainset_loader;

    localparam int N  = 17;
    localparam int N3 = 4;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        start_i = 1'b0;
    logic        wr_valid_i = 1'b0;
    logic        wr_ready_o;
    logic [31:0] wr_point_i = '0;
    logic [0:0]  wr_class_i = '0;
    logic [31:0] points_o [N];
    logic [0:0]  classes_o [N];
    logic [4:0]  count_o;
    logic        loaded_o;
    logic        err_o;

    logic        s3_start = 1'b0;
    logic        s3_valid = 1'b0;
    logic        s3_ready;
    logic [31:0] s3_point = '0;
    logic [1:0]  s3_class = '0;
    logic [31:0] s3_points [N3];
    logic [1:0]  s3_classes [N3];
    logic [2:0]  s3_count;
    logic        s3_loaded;
    logic        s3_err;

    knn_trainset_loader dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_point_i(wr_point_i), .wr_class_i(wr_class_i),
        .points_o(points_o), .classes_o(classes_o),
        .count_o(count_o), .loaded_o(loaded_o), .err_o(err_o)
    );

    knn_trainset_loader #(.NPoints(N3), .Classes(3), .CoordW(16)) dut3 (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(s3_start),
        .wr_valid_i(s3_valid), .wr_ready_o(s3_ready),
        .wr_point_i(s3_point), .wr_class_i(s3_class),
        .points_o(s3_points), .classes_o(s3_classes),
        .count_o(s3_count), .loaded_o(s3_loaded), .err_o(s3_err)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: the training set as seen by the classifier.
    logic [31:0] m_pt [N];
    logic        m_cl [N];
    int          m_count = 0;
    bit          m_loading = 0;
    bit          m_loaded = 0;
    bit          m_err = 0;

    typedef struct {
        int          cnt;
        bit          loaded;
        bit          err;
        bit          ready;
        int          idx;
        logic [31:0] pt;
        logic        cl;
        bit          full;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pt[i] = '0;
            m_cl[i] = 1'b0;
        end
        m_count = 0;
        m_loading = 0;
        m_loaded = 0;
        m_err = 0;
    endtask

    // One clock of stimulus; the model advances with the edge and the expected
    // post-edge picture is queued for the monitor.
    task automatic drive(input bit st, input bit v, input logic [31:0] p, input logic c, input bit full);
        exp_t e;
        start_i = st;
        wr_valid_i = v;
        wr_point_i = p;
        wr_class_i = c;
        @(posedge clk_i);
        e.idx = -1;
        if (st) begin
            m_loading = 1;
            m_loaded = 0;
            m_count = 0;
            m_err = 0;
        end else if (m_loading && v) begin
            m_pt[m_count] = p;
            m_cl[m_count] = c;
            e.idx = m_count;
            m_count++;
            if (m_count == N) begin
                m_loading = 0;
                m_loaded = 1;
            end
        end
        e.cnt = m_count;
        e.loaded = m_loaded;
        e.err = m_err;
        e.ready = m_loading;
        e.pt = p;
        e.cl = c;
        e.full = full;
        #1;
        q.push_back(e);
        start_i = 1'b0;
        wr_valid_i = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() > 0 && k < 20) begin
            @(negedge clk_i);
            #1;
            k++;
        end
        chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_count"}, 64'(count_o), 64'd0);
        chk({tag, "_loaded"}, 64'(loaded_o), 64'd0);
        chk({tag, "_err"}, 64'(err_o), 64'd0);
        chk({tag, "_ready"}, 64'(wr_ready_o), 64'd0);
        for (int i = 0; i < N; i++) begin
            chk({tag, "_pt"}, 64'(points_o[i]), 64'd0);
            chk({tag, "_cl"}, 64'(classes_o[i]), 64'd0);
        end
    endtask

    // Monitor: compares each queued expectation against the outputs mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("count", 64'(count_o), 64'(e.cnt));
                chk("loaded", 64'(loaded_o), 64'(e.loaded));
                chk("err", 64'(err_o), 64'(e.err));
                chk("ready", 64'(wr_ready_o), 64'(e.ready));
                if (e.idx >= 0) begin
                    chk("entry_pt", 64'(points_o[e.idx]), 64'(e.pt));
                    chk("entry_cl", 64'(classes_o[e.idx]), 64'(e.cl));
                end
                if (e.full) begin
                    for (int i = 0; i < N; i++) begin
                        chk("bank_pt", 64'(points_o[i]), 64'(m_pt[i]));
                        chk("bank_cl", 64'(classes_o[i]), 64'(m_cl[i]));
                    end
                end
            end
        end
    end

    task automatic d3(input bit st, input bit v, input logic [1:0] c);
        s3_start = st;
        s3_valid = v;
        s3_point = $urandom;
        s3_class = c;
        @(posedge clk_i);
        #1;
        s3_start = 1'b0;
        s3_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        // Test 1: reset values, then writes in IDLE are ignored.
        repeat (3) @(posedge clk_i);
        #1;
        check_zero("rst");
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 5; i++) drive(0, 1, $urandom, 1'($urandom), 1);
        drain();

        // Test 2: back-to-back load of the reference pattern.
        drive(1, 0, '0, 0, 0);
        for (int i = 0; i < N; i++) drive(0, 1, {16'(i), 16'(2 * i)}, 1'(i % 2), 0);
        drain();
        chk("t2_pt16", 64'(points_o[16]), 64'h0010_0020);
        chk("t2_cl16", 64'(classes_o[16]), 64'd0);
        // Records offered in DONE are refused.
        for (int i = 0; i < 3; i++) drive(0, 1, $urandom, 1'($urandom), 1);

        // Test 3: same pattern with random valid gaps.
        drive(1, 0, '0, 0, 1);
        for (int i = 0; i < N; i++) begin
            while ($urandom_range(0, 2) == 0) drive(0, 0, $urandom, 1'($urandom), 0);
            drive(0, 1, {16'(i), 16'(2 * i)}, 1'(i % 2), 0);
        end
        drive(0, 0, '0, 0, 1);

        // Test 6: restart after DONE keeps old entries until rewritten.
        drive(1, 0, '0, 0, 1);
        for (int i = 0; i < 2; i++) drive(0, 1, $urandom, 1'($urandom), 1);

        // Test 4: start together with a valid record drops the record.
        drive(1, 0, '0, 0, 0);
        for (int i = 0; i < 9; i++) drive(0, 1, $urandom, 1'($urandom), 0);
        drive(1, 1, 32'hdead_beef, 1, 1);
        drive(0, 1, $urandom, 1'($urandom), 1);
        for (int i = 0; i < 6; i++) drive(0, $urandom_range(0, 1), $urandom, 1'($urandom), 0);
        drain();

        // Test 5: reset in the middle of a load.
        drive(1, 0, '0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, $urandom, 1'($urandom), 0);
        drain();
        rstn_i = 1'b0;
        #1;
        check_zero("midrst");
        model_reset();
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        drive(0, 1, $urandom, 1'($urandom), 1);
        drain();

        // Three-class instance: label 3 is out of range and sets err sticky.
        d3(1, 0, 0);
        chk("c3_ready", 64'(s3_ready), 64'd1);
        chk("c3_err0", 64'(s3_err), 64'd0);
        d3(0, 1, 2'd1);
        chk("c3_err_ok", 64'(s3_err), 64'd0);
        d3(0, 1, 2'd3);
        chk("c3_err_set", 64'(s3_err), 64'd1);
        chk("c3_cls_stored", 64'(s3_classes[1]), 64'd3);
        chk("c3_count", 64'(s3_count), 64'd2);
        d3(0, 0, 2'd0);
        chk("c3_err_hold", 64'(s3_err), 64'd1);
        d3(0, 1, 2'd0);
        d3(0, 1, 2'd2);
        chk("c3_loaded", 64'(s3_loaded), 64'd1);
        chk("c3_err_done", 64'(s3_err), 64'd1);
        d3(1, 0, 2'd0);
        chk("c3_err_clr", 64'(s3_err), 64'd0);
        chk("c3_loaded_clr", 64'(s3_loaded), 64'd0);
        chk("c3_old_kept", 64'(s3_classes[3]), 64'd2);

        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
